// File: rtl/control_pkg.sv
// Shared types and constants for the instruction-sequencing controller.
// State set includes JMPZ only when CTRL_JMPZ_EN is defined.
package control_pkg;

    localparam int unsigned CTRL_PC_W = 7;
    localparam int unsigned IR_W      = 16;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned REG_W     = 4;
    localparam int unsigned DADDR_W   = 8;
    localparam int unsigned ALU_W     = 2;

    localparam int unsigned OP_MSB = 15;
    localparam int unsigned OP_LSB = 12;
    localparam int unsigned RA_MSB = 11;
    localparam int unsigned RA_LSB = 8;
    localparam int unsigned RB_MSB = 7;
    localparam int unsigned RB_LSB = 4;
    localparam int unsigned RC_MSB = 3;
    localparam int unsigned RC_LSB = 0;
    localparam int unsigned D_MSB  = 7;
    localparam int unsigned D_LSB  = 0;

    localparam logic [OP_W-1:0] OP_NOOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_STORE = 4'h1;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD   = 4'h3;
    localparam logic [OP_W-1:0] OP_SUB   = 4'h4;
    localparam logic [OP_W-1:0] OP_HALT  = 4'h5;
    localparam logic [OP_W-1:0] OP_JMPZ  = 4'h6;

    localparam logic [ALU_W-1:0] ALU_PASS = 2'b00;
    localparam logic [ALU_W-1:0] ALU_ADD  = 2'b01;
    localparam logic [ALU_W-1:0] ALU_SUB  = 2'b10;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
`ifdef CTRL_JMPZ_EN
        , ST_JMPZ = 4'd10
`endif
    } state_t;

    typedef struct packed {
        logic [DADDR_W-1:0] d_addr;
        logic               d_rd;
        logic               d_wr;
        logic               rf_s;
        logic [REG_W-1:0]   rf_w_addr;
        logic               rf_w_en;
        logic [REG_W-1:0]   rf_rp_addr;
        logic               rf_rp_rd;
        logic [REG_W-1:0]   rf_rq_addr;
        logic               rf_rq_rd;
        logic [ALU_W-1:0]   alu_s0;
        logic               halted;
    } ctrl_t;

    // Moore decode: control word presented while in state st holding ir.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [IR_W-1:0] ir);
        ctrl_t c;
        c        = '0;
        c.alu_s0 = ALU_PASS;
        case (st)
            ST_LOAD_A: begin
                c.d_addr = ir[D_MSB:D_LSB];
                c.d_rd   = 1'b1;
            end
            ST_LOAD_B: begin
                c.d_addr    = ir[D_MSB:D_LSB];
                c.rf_s      = 1'b1;
                c.rf_w_addr = ir[RA_MSB:RA_LSB];
                c.rf_w_en   = 1'b1;
            end
            ST_STORE: begin
                c.d_addr     = ir[D_MSB:D_LSB];
                c.d_wr       = 1'b1;
                c.rf_rp_addr = ir[RA_MSB:RA_LSB];
                c.rf_rp_rd   = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                c.rf_rp_addr = ir[RB_MSB:RB_LSB];
                c.rf_rp_rd   = 1'b1;
                c.rf_rq_addr = ir[RC_MSB:RC_LSB];
                c.rf_rq_rd   = 1'b1;
                c.alu_s0     = (st == ST_ADD) ? ALU_ADD : ALU_SUB;
                c.rf_w_addr  = ir[RA_MSB:RA_LSB];
                c.rf_w_en    = 1'b1;
            end
`ifdef CTRL_JMPZ_EN
            ST_JMPZ: begin
                c.rf_rp_addr = ir[RA_MSB:RA_LSB];
                c.rf_rp_rd   = 1'b1;
            end
`endif
            ST_HALT: c.halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: async clear, sync clear, increment and PC-relative load.
module pc_counter #(
    parameter int unsigned PC_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    input  logic            i_inc,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_ofs,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    // Relative load adds to the already-incremented PC; all arithmetic wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (i_clr) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= r_pc + i_ofs;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing controller: PC, IR, FSM and registered control decode.
// Define CTRL_JMPZ_EN to enable the conditional relative jump (opcode 0110).
module control_unit
    import control_pkg::*;
#(
    parameter int unsigned PC_W = CTRL_PC_W
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [IR_W-1:0]    IM_data,
    input  logic               Rp_zero,
    output logic [PC_W-1:0]    IM_addr,
    output logic [IR_W-1:0]    IR_out,
    output logic [DADDR_W-1:0] D_addr,
    output logic               D_rd,
    output logic               D_wr,
    output logic               RF_s,
    output logic [REG_W-1:0]   RF_W_addr,
    output logic               RF_W_en,
    output logic [REG_W-1:0]   RF_Rp_addr,
    output logic               RF_Rp_rd,
    output logic [REG_W-1:0]   RF_Rq_addr,
    output logic               RF_Rq_rd,
    output logic [ALU_W-1:0]   ALU_s0,
    output logic               Halted
);

    state_t          r_state;
    state_t          w_state_next;
    logic [IR_W-1:0] r_ir;
    logic [IR_W-1:0] w_ir_next;
    ctrl_t           r_ctrl;
    ctrl_t           w_ctrl_next;
    logic            w_pc_clr;
    logic            w_pc_inc;
    logic            w_pc_load;
    logic [PC_W-1:0] w_pc;
    logic [PC_W-1:0] w_pc_ofs;
    logic [OP_W-1:0] w_op;

    assign w_op     = r_ir[OP_MSB:OP_LSB];
    assign w_pc_ofs = PC_W'({{8{r_ir[D_MSB]}}, r_ir[D_MSB:D_LSB]});

    pc_counter #(.PC_W(PC_W)) u_pc (
        .clk    (Clk),
        .rst_n  (Reset),
        .i_clr  (w_pc_clr),
        .i_inc  (w_pc_inc),
        .i_load (w_pc_load),
        .i_ofs  (w_pc_ofs),
        .o_pc   (w_pc)
    );

    // Control word is registered from the next state so outputs track the state with no lag.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_INIT;
            r_ir    <= '0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_next;
            r_ir    <= w_ir_next;
            r_ctrl  <= w_ctrl_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ir_next    = r_ir;
        w_pc_clr     = 1'b0;
        w_pc_inc     = 1'b0;
        w_pc_load    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_pc_clr     = 1'b1;
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_ir_next    = IM_data;
                w_pc_inc     = 1'b1;
                w_state_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_op)
                    OP_NOOP:  w_state_next = ST_NOOP;
                    OP_STORE: w_state_next = ST_STORE;
                    OP_LOAD:  w_state_next = ST_LOAD_A;
                    OP_ADD:   w_state_next = ST_ADD;
                    OP_SUB:   w_state_next = ST_SUB;
                    OP_HALT:  w_state_next = ST_HALT;
`ifdef CTRL_JMPZ_EN
                    OP_JMPZ:  w_state_next = ST_JMPZ;
`else
                    OP_JMPZ:  w_state_next = ST_NOOP;
`endif
                    default:  w_state_next = ST_NOOP;
                endcase
            end
            ST_LOAD_A: w_state_next = ST_LOAD_B;
            ST_NOOP, ST_LOAD_B, ST_STORE, ST_ADD, ST_SUB: w_state_next = ST_FETCH;
`ifdef CTRL_JMPZ_EN
            ST_JMPZ: begin
                w_pc_load    = Rp_zero;
                w_state_next = ST_FETCH;
            end
`endif
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_INIT;
        endcase
        w_ctrl_next = decode_ctrl(w_state_next, w_ir_next);
    end

`ifndef CTRL_JMPZ_EN
    logic w_unused_rp_zero;
    assign w_unused_rp_zero = Rp_zero;
`endif

    assign IM_addr    = w_pc;
    assign IR_out     = r_ir;
    assign D_addr     = r_ctrl.d_addr;
    assign D_rd       = r_ctrl.d_rd;
    assign D_wr       = r_ctrl.d_wr;
    assign RF_s       = r_ctrl.rf_s;
    assign RF_W_addr  = r_ctrl.rf_w_addr;
    assign RF_W_en    = r_ctrl.rf_w_en;
    assign RF_Rp_addr = r_ctrl.rf_rp_addr;
    assign RF_Rp_rd   = r_ctrl.rf_rp_rd;
    assign RF_Rq_addr = r_ctrl.rf_rq_addr;
    assign RF_Rq_rd   = r_ctrl.rf_rq_rd;
    assign ALU_s0     = r_ctrl.alu_s0;
    assign Halted     = r_ctrl.halted;

endmodule
